// File: rtl/mul_share_arbiter_if.sv
// Bundle between the compute cores, the shared-multiplier arbiter and the single booth multiplier.
// slave = arbiter view; master = the cores/multiplier (or bench) view.
interface mul_share_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 64
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] op_a;
  logic [NUM_REQ*DATA_W-1:0] op_b;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [NUM_REQ-1:0]        err;
  logic [2*DATA_W-1:0]       result;
  logic                      busy;
  logic [DATA_W-1:0]         m_multiplier;
  logic [DATA_W-1:0]         m_multiplicand;
  logic                      m_op_start;
  logic                      m_op_clear;
  logic                      m_op_done;
  logic [2*DATA_W-1:0]       m_result;

  modport slave (
    input  req, op_a, op_b, m_op_done, m_result,
    output gnt, done, err, result, busy,
           m_multiplier, m_multiplicand, m_op_start, m_op_clear
  );

  modport master (
    output req, op_a, op_b, m_op_done, m_result,
    input  gnt, done, err, result, busy,
           m_multiplier, m_multiplicand, m_op_start, m_op_clear
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin share of one multiplier among NUM_REQ cores; grant 1 cycle after req, done/err 1 cycle after exit.
// No queuing: a core holds req until its done/err; dropping req mid-run aborts silently.
module mul_share_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mul_share_arbiter_if.slave    arb
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_CLEAR = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [NUM_REQ-1:0]  err_q, err_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [DATA_W-1:0]   mcand_q, mcand_d;
  logic                start_q, start_d;
  logic                clear_q, clear_d;

  logic                win_vld;
  logic [PW-1:0]       win_idx;
  logic [PW-1:0]       cand;
  logic [PW-1:0]       ptr_nxt;
  logic [NUM_REQ-1:0]  win_oh;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic                go_clear;

  // First requester at or after ptr, wrapping.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PW'((int'(ptr_q) + i) % NUM_REQ);
      if (!win_vld && arb.req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    win_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PW'(i)) begin
        sel_a     = arb.op_a[i*DATA_W +: DATA_W];
        sel_b     = arb.op_b[i*DATA_W +: DATA_W];
        win_oh[i] = 1'b1;
      end
    end
  end

  assign ptr_nxt = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    err_d    = '0;
    result_d = result_q;
    busy_d   = busy_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    start_d  = start_q;
    clear_d  = 1'b0;
    go_clear = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          mplier_d = sel_a;
          mcand_d  = sel_b;
          gnt_d    = win_oh;
          ptr_d    = ptr_nxt;
          start_d  = 1'b1;
          busy_d   = 1'b1;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        // Completion outranks both abort and timeout in the same cycle.
        if (arb.m_op_done) begin
          result_d = arb.m_result;
          done_d   = gnt_q;
          go_clear = 1'b1;
        end else if (~|(arb.req & gnt_q)) begin
          go_clear = 1'b1;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d    = gnt_q;
          go_clear = 1'b1;
        end
        if (go_clear) begin
          state_d = S_CLEAR;
          start_d = 1'b0;
          clear_d = 1'b1;
          gnt_d   = '0;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        start_d = 1'b0;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      mplier_q <= '0;
      mcand_q  <= '0;
      start_q  <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      start_q  <= start_d;
      clear_q  <= clear_d;
    end
  end

  assign arb.gnt            = gnt_q;
  assign arb.done           = done_q;
  assign arb.err            = err_q;
  assign arb.result         = result_q;
  assign arb.busy           = busy_q;
  assign arb.m_multiplier   = mplier_q;
  assign arb.m_multiplicand = mcand_q;
  assign arb.m_op_start     = start_q;
  assign arb.m_op_clear     = clear_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Transaction-level bench: bench plays both cores and the multiplier, predicting winner, product and exit cause.
module tb_mul_share_arbiter;

  localparam int TMO = 16;

  logic clk;
  logic reset_n;

  mul_share_arbiter_if #(.NUM_REQ(2), .DATA_W(64)) bus ();

  mul_share_arbiter #(.NUM_REQ(2), .DATA_W(64), .TIMEOUT(TMO)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .arb     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           ptr_m = 0;
  logic [127:0] last_res = '0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Starts and ends at a negedge with the arbiter idle. Exit codes: 0 run, 1 done, 2 drop, 3 timeout.
  task automatic run_op(input logic [1:0] reqm, input logic [63:0] a0, input logic [63:0] b0,
                        input logic [63:0] a1, input logic [63:0] b1,
                        input int lat, input bit hang, input int drop_at);
    int           w;
    int           ex;
    bit           fin;
    logic [63:0]  ea, eb;
    logic [127:0] prod;
    logic [1:0]   oh;
    w = -1;
    for (int i = 0; i < 2; i++) begin
      int k;
      k = (ptr_m + i) % 2;
      if (w < 0 && reqm[k]) w = k;
    end
    ea   = (w == 1) ? a1 : a0;
    eb   = (w == 1) ? b1 : b0;
    prod = {64'd0, ea} * {64'd0, eb};
    oh   = (w == 1) ? 2'b10 : 2'b01;
    bus.req  = reqm;
    bus.op_a = {a1, a0};
    bus.op_b = {b1, b0};
    @(negedge clk);
    chk("gnt", bus.gnt, oh);
    chk("start", bus.m_op_start, 1);
    chk("mplier", bus.m_multiplier, ea);
    chk("mcand", bus.m_multiplicand, eb);
    chk("busy_run", bus.busy, 1);
    chk("done_early", bus.done, 0);
    ptr_m = (w + 1) % 2;
    fin = 0;
    for (int j = 1; j <= TMO + 4 && !fin; j++) begin
      ex = 0;
      bus.m_result = rnd128();
      if (!hang && j == lat) begin
        bus.m_op_done = 1'b1;
        bus.m_result  = prod;
        ex = 1;
      end else if (j == drop_at) begin
        bus.req[w] = 1'b0;
        ex = 2;
      end else if (j == TMO) begin
        ex = 3;
      end
      @(negedge clk);
      bus.m_op_done = 1'b0;
      bus.m_result  = rnd128();
      if (ex == 0) begin
        chk("gnt_hold", bus.gnt, oh);
        chk("start_hold", bus.m_op_start, 1);
        chk("mplier_hold", bus.m_multiplier, ea);
        chk("clear_run", bus.m_op_clear, 0);
        chk("pulse_run", {bus.done, bus.err}, 0);
      end else begin
        fin = 1;
        if (ex == 1) last_res = prod;
        chk("clear", bus.m_op_clear, 1);
        chk("gnt_clr", bus.gnt, 0);
        chk("start_clr", bus.m_op_start, 0);
        chk("done", bus.done, (ex == 1) ? oh : 2'b00);
        chk("err", bus.err, (ex == 3) ? oh : 2'b00);
        chk("result", bus.result, last_res);
        chk("busy_clr", bus.busy, 1);
      end
    end
    chk("run_exit", fin, 1);
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    chk("idle_clear", bus.m_op_clear, 0);
    chk("idle_pulse", {bus.done, bus.err}, 0);
    chk("idle_result", bus.result, last_res);
  endtask

  initial begin
    bus.req       = '0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.m_op_done = 1'b0;
    bus.m_result  = '0;
    reset_n       = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_pulse", {bus.done, bus.err}, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_mops", {bus.m_multiplier, bus.m_multiplicand, bus.m_op_start, bus.m_op_clear}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single request, small operands.
    run_op(2'b01, 64'd3, 64'd5, rnd64(), rnd64(), 3, 0, 0);
    chk("single_15", bus.result, 128'd15);
    run_op(2'b10, rnd64(), rnd64(), rnd64(), rnd64(), 2, 0, 0);

    // Contention with both held: alternates starting at requester 0.
    for (int n = 0; n < 4; n++)
      run_op(2'b11, rnd64(), rnd64(), rnd64(), rnd64(), $urandom_range(1, 12), 0, 0);

    // Widest product.
    run_op(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, rnd64(), rnd64(), 5, 0, 0);
    chk("wide", bus.result, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

    // Multiplier never answers.
    run_op(2'b01, rnd64(), rnd64(), rnd64(), rnd64(), 1, 1, 0);
    // Done in the same cycle as the timeout.
    run_op(2'b01, rnd64(), rnd64(), rnd64(), rnd64(), TMO, 0, 0);
    // Requester 1 aborts, then requester 0 is next.
    run_op(2'b11, rnd64(), rnd64(), rnd64(), rnd64(), 12, 0, 4);
    run_op(2'b11, rnd64(), rnd64(), rnd64(), rnd64(), 3, 0, 0);

    for (int n = 0; n < 24; n++) begin
      int drop;
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TMO) : 0;
      run_op(2'($urandom_range(1, 3)), rnd64(), rnd64(), rnd64(), rnd64(),
             $urandom_range(1, TMO + 2), 0, drop);
    end

    // Reset while running, with a done pending on the multiplier side.
    bus.req  = 2'b01;
    bus.op_a = {rnd64(), rnd64()};
    bus.op_b = {rnd64(), rnd64()};
    @(negedge clk);
    chk("pre_rst_gnt", bus.gnt, 2'b01);
    repeat (2) @(negedge clk);
    bus.m_op_done = 1'b1;
    bus.m_result  = rnd128();
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_gnt", bus.gnt, 0);
    chk("mid_rst_pulse", {bus.done, bus.err}, 0);
    chk("mid_rst_result", bus.result, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_mops", {bus.m_multiplier, bus.m_multiplicand, bus.m_op_start, bus.m_op_clear}, 0);
    @(negedge clk);
    bus.m_op_done = 1'b0;
    bus.req       = '0;
    @(negedge clk);
    reset_n  = 1'b1;
    ptr_m    = 0;
    last_res = '0;
    chk("post_rst_pulse", {bus.done, bus.err}, 0);
    run_op(2'b10, rnd64(), rnd64(), rnd64(), rnd64(), 4, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
